// File: rtl/gsim_pkg.sv
// Shared definitions for the banded multiplier and its Gauss-Seidel solver.
// Holds the vector geometry, word widths, FSM state encoding, band
// coefficients and a sign-extension helper.
package gsim_pkg;

  localparam int N    = 16;
  localparam int XW   = 32;
  localparam int BW   = 16;
  localparam int FRAC = 16;
  localparam int AW   = 40;
  localparam int CW   = 4;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  // Band magnitudes; signs are +C0, -C1, +C2, -C3 moving away from the diagonal.
  localparam int C0 = 20;
  localparam int C1 = 13;
  localparam int C2 = 6;
  localparam int C3 = 1;

  typedef enum logic [1:0] {
    RECV = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_t;

  function automatic logic signed [AW-1:0] sext(input logic signed [XW-1:0] v);
    return {{(AW-XW){v[XW-1]}}, v};
  endfunction

endpackage

// File: rtl/gsim_round_sat.sv
// Accumulator-to-output conversion: round half toward +inf at the Q16.16
// binary point, then clamp to the signed BW-bit range.
// Ports:
//   i_acc  signed AW-bit accumulator (Q.FRAC)
//   o_b    signed BW-bit rounded, saturated integer
module gsim_round_sat
  import gsim_pkg::*;
(
  input  logic signed [AW-1:0] i_acc,
  output logic signed [BW-1:0] o_b
);

  localparam logic signed [AW-1:0] HALF  = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [AW-1:0] MAX_B = {{(AW-BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_B = ~MAX_B;

  logic signed [AW-1:0] w_biased;
  logic signed [AW-1:0] w_r;

  always_comb begin
    w_biased = i_acc + HALF;
    w_r      = w_biased >>> FRAC;
    if (w_r > MAX_B) begin
      o_b = MAX_B[BW-1:0];
    end else if (w_r < MIN_B) begin
      o_b = MIN_B[BW-1:0];
    end else begin
      o_b = w_r[BW-1:0];
    end
  end

endmodule

// File: rtl/gsim_band_mul.sv
// Forward 7-band matrix-vector multiplier b = A*x for a 16-element Q16.16
// vector. Collects x, computes one row every two cycles, then streams b.
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_en      x_in valid (accepted only in RECV)
//   x_in       x[k], signed Q16.16, k = 0..15 in order
//   busy       high in CALC and SEND
//   out_valid  b_out valid
//   b_out      b[i], signed 16-bit, i = 0..15 in order
//
// state | meaning
// ------+---------------------------------------------------------
// RECV  | collecting x[0..15]; cnt is the next write index
// CALC  | row cnt: stage 0 gathers neighbour sums, stage 1 writes b
// SEND  | streaming bbuf[cnt], one element per cycle
module gsim_band_mul
  import gsim_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_en,
  input  logic signed [XW-1:0] x_in,
  output logic                 busy,
  output logic                 out_valid,
  output logic signed [BW-1:0] b_out
);

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic               r_stage, w_stage_nxt;
  logic               w_x_we, w_b_we;

  logic signed [XW-1:0] r_xbuf [N];
  logic signed [BW-1:0] r_bbuf [N];

  logic signed [AW-1:0] r_d, r_s1, r_s2, r_s3;
  logic signed [XW-1:0] w_xm1, w_xm2, w_xm3, w_xp1, w_xp2, w_xp3;
  logic signed [AW-1:0] w_acc;
  logic signed [BW-1:0] w_b_rs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RECV;
      r_cnt   <= '0;
      r_stage <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stage <= w_stage_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    w_x_we      = 1'b0;
    w_b_we      = 1'b0;
    case (r_state)
      RECV: begin
        if (in_en) begin
          w_x_we = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = CALC;
            w_cnt_nxt   = '0;
            w_stage_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      CALC: begin
        if (!r_stage) begin
          w_stage_nxt = 1'b1;
        end else begin
          w_stage_nxt = 1'b0;
          w_b_we      = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = SEND;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      SEND: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = RECV;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = RECV;
        w_cnt_nxt   = '0;
        w_stage_nxt = 1'b0;
      end
    endcase
  end

  // Neighbour fetch; the 4-bit index arithmetic wraps at the edges, so the
  // wrapped reads are replaced with zero padding for rows 0..2 and 13..15.
  always_comb begin
    w_xm1 = r_xbuf[r_cnt - 4'd1];
    w_xm2 = r_xbuf[r_cnt - 4'd2];
    w_xm3 = r_xbuf[r_cnt - 4'd3];
    w_xp1 = r_xbuf[r_cnt + 4'd1];
    w_xp2 = r_xbuf[r_cnt + 4'd2];
    w_xp3 = r_xbuf[r_cnt + 4'd3];
    case (r_cnt)
      4'd0: begin
        w_xm1 = '0;
        w_xm2 = '0;
        w_xm3 = '0;
      end
      4'd1: begin
        w_xm2 = '0;
        w_xm3 = '0;
      end
      4'd2: w_xm3 = '0;
      4'd13: w_xp3 = '0;
      4'd14: begin
        w_xp2 = '0;
        w_xp3 = '0;
      end
      4'd15: begin
        w_xp1 = '0;
        w_xp2 = '0;
        w_xp3 = '0;
      end
      default: ;
    endcase
  end

  // 20d - 13s1 + 6s2 - s3 built from shifts: 20=16+4, 13=8+4+1, 6=4+2.
  always_comb begin
    w_acc = (r_d <<< 4) + (r_d <<< 2)
          - ((r_s1 <<< 3) + (r_s1 <<< 2) + r_s1)
          + (r_s2 <<< 2) + (r_s2 <<< 1)
          - r_s3;
  end

  gsim_round_sat u_round_sat (
    .i_acc (w_acc),
    .o_b   (w_b_rs)
  );

  always_ff @(posedge clk) begin
    if (w_x_we) begin
      r_xbuf[r_cnt] <= x_in;
    end
    if (r_state == CALC && !r_stage) begin
      r_d  <= sext(r_xbuf[r_cnt]);
      r_s1 <= sext(w_xm1) + sext(w_xp1);
      r_s2 <= sext(w_xm2) + sext(w_xp2);
      r_s3 <= sext(w_xm3) + sext(w_xp3);
    end
    if (w_b_we) begin
      r_bbuf[r_cnt] <= w_b_rs;
    end
  end

  assign busy      = (r_state != RECV);
  assign out_valid = (r_state == SEND);
  assign b_out     = r_bbuf[r_cnt];

endmodule

// File: tb/tb_gsim_band_mul.sv
module tb_gsim_band_mul;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               in_en = 1'b0;
  logic signed [31:0] x_in = '0;
  logic               busy;
  logic               out_valid;
  logic signed [15:0] b_out;

  gsim_band_mul dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_en     (in_en),
    .x_in      (x_in),
    .busy      (busy),
    .out_valid (out_valid),
    .b_out     (b_out)
  );

  always #5 clk = ~clk;

  int                 n_chk = 0;
  int                 n_pass = 0;
  int                 sb[$];
  logic signed [31:0] xv [16];
  int                 exp_v [16];
  int                 mon_idx = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference row product using plain multiplies on 64-bit integers.
  function automatic int model_b(input int i);
    longint acc = 0;
    longint r;
    int     coef;
    for (int j = -3; j <= 3; j++) begin
      if (i + j >= 0 && i + j <= 15) begin
        case (j < 0 ? -j : j)
          0: coef = 20;
          1: coef = -13;
          2: coef = 6;
          default: coef = -1;
        endcase
        acc += longint'(coef) * longint'(xv[i+j]);
      end
    end
    r = (acc + 64'sd32768) >>> 16;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 0);
      end else begin
        chk($sformatf("b_out[%0d]", mon_idx), b_out, sb.pop_front());
      end
      mon_idx++;
    end else begin
      mon_idx = 0;
    end
  end

  // gap < 0 means random gaps of 0..3 idle cycles; mode 0: no push,
  // 1: push exp_v, 2: push model.
  task automatic send_frame(input int gap, input int mode);
    int g;
    for (int i = 0; i < 16; i++) begin
      if (mode == 1) sb.push_back(exp_v[i]);
      if (mode == 2) sb.push_back(model_b(i));
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      in_en = 1'b1;
      x_in  = xv[k];
      @(posedge clk);
      #1;
      in_en = 1'b0;
      x_in  = 32'h0BAD_0BAD;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      if (k < 15) repeat (g) @(posedge clk);
    end
  endtask

  // Called at edge E + 1ns. Optionally pulses in_en during CALC.
  task automatic check_timing(input string tag, input bit pulse);
    int cyc;
    int len;
    chk({tag, "_busy_at_E"}, busy, 1);
    chk({tag, "_ov_at_E"}, out_valid, 0);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      if (pulse && cyc >= 2 && cyc <= 5) begin
        in_en = 1'b1;
        x_in  = 32'h1234_5678;
      end else begin
        in_en = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_en = 1'b0;
    chk({tag, "_latency"}, cyc, 32);
    len = 0;
    while (out_valid === 1'b1 && len < 40) begin
      chk({tag, "_busy_in_send"}, busy, 1);
      @(posedge clk);
      #1;
      len++;
    end
    chk({tag, "_ov_len"}, len, 16);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int ovc;

    #3 reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // All zeros.
    for (int i = 0; i < 16; i++) begin xv[i] = '0; exp_v[i] = 0; end
    send_frame(0, 1);
    check_timing("zeros", 1'b0);

    // Unit spike at x[5], with gaps.
    for (int i = 0; i < 16; i++) begin xv[i] = '0; exp_v[i] = 0; end
    xv[5] = 32'h0001_0000;
    exp_v[2] = -1; exp_v[3] = 6; exp_v[4] = -13; exp_v[5] = 20;
    exp_v[6] = -13; exp_v[7] = 6; exp_v[8] = -1;
    send_frame(2, 1);
    check_timing("spike", 1'b0);

    // All ones, with in_en pulses during CALC.
    for (int i = 0; i < 16; i++) begin xv[i] = 32'h0001_0000; exp_v[i] = 4; end
    exp_v[0] = 12; exp_v[1] = -1; exp_v[2] = 5;
    exp_v[13] = 5; exp_v[14] = -1; exp_v[15] = 12;
    send_frame(0, 1);
    check_timing("ones_pulse", 1'b1);

    // Half at x[0] exercises round-half-up.
    for (int i = 0; i < 16; i++) begin xv[i] = '0; exp_v[i] = 0; end
    xv[0] = 32'h0000_8000;
    exp_v[0] = 10; exp_v[1] = -6; exp_v[2] = 3;
    send_frame(0, 1);
    check_timing("round", 1'b0);

    // Positive saturation.
    for (int i = 0; i < 16; i++) xv[i] = 32'h7FFF_0000;
    send_frame(0, 2);
    check_timing("sat_pos", 1'b0);

    // Alternating +/-1000.0.
    for (int i = 0; i < 16; i++) xv[i] = (i % 2 == 0) ? 32'sd65536000 : -32'sd65536000;
    send_frame(1, 2);
    check_timing("sat_alt", 1'b0);

    // Random values, random gaps.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) xv[i] = $signed($urandom());
      send_frame(-1, 2);
      check_timing("rand", 1'b0);
      for (int i = 0; i < 16; i++) xv[i] = $signed($urandom_range(0, 32'h0010_0000)) - 32'sd524288;
      send_frame(-1, 2);
      check_timing("rand_small", 1'b0);
    end

    // Reset in CALC cycle 10: frame must be discarded.
    for (int i = 0; i < 16; i++) xv[i] = 32'h0003_0000;
    send_frame(0, 0);
    repeat (9) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk) reset_n = 1'b1;
    ovc = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) ovc++;
    end
    chk("midrst_no_output", ovc, 0);

    for (int i = 0; i < 16; i++) xv[i] = 32'sd40000 * (i - 7);
    send_frame(0, 2);
    check_timing("after_rst", 1'b0);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
